// File: rtl/am_envelope_det.sv
// rtl/am_envelope_det.sv - AM envelope detector: DC removal, full-wave rectify, boxcar average
module am_envelope_det #(
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 5,
    parameter int DC_SHIFT = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              dc_mode,
    input  logic [DATA_W-1:0] dc_offset,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dc_est
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int ACC_W = DATA_W + DC_SHIFT;
    localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(DEPTH - 1);

    // DC tracker
    logic [ACC_W-1:0] dc_acc;
    logic [ACC_W-1:0] dc_acc_next;

    // Wraps mod 2^ACC_W in the middle, but the true result always fits ACC_W bits.
    assign dc_acc_next = dc_acc + ACC_W'(din) - (dc_acc >> DC_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_acc <= {dc_offset, {DC_SHIFT{1'b0}}};
            dc_est <= dc_offset;
        end else if (din_valid) begin
            dc_acc <= dc_acc_next;
            dc_est <= dc_acc_next[ACC_W-1:DC_SHIFT];
        end
    end

    // S1: offset subtraction at DATA_W+1 bits signed
    logic [DATA_W-1:0]        off;
    logic signed [DATA_W:0]   ac_next;
    logic signed [DATA_W:0]   ac_r;
    logic                     v1;

    assign off     = dc_mode ? dc_est : dc_offset;
    assign ac_next = $signed({1'b0, din}) - $signed({1'b0, off});

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else begin
            v1 <= din_valid;
            if (din_valid) begin
                ac_r <= ac_next;
            end
        end
    end

    // S2: full-wave rectification; |ac| <= 2^DATA_W-1 so no saturation needed
    logic [DATA_W-1:0] mag_next;
    logic [DATA_W-1:0] mag_r;
    logic              v2;

    assign mag_next = ac_r[DATA_W] ? (~ac_r[DATA_W-1:0] + DATA_W'(1)) : ac_r[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                mag_r <= mag_next;
            end
        end
    end

    // S3a: circular buffer; oldest reads as 0 until the window has filled
    logic [DATA_W-1:0]   win_mem [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr;
    logic [AVG_LOG2:0]   fill;
    logic [DATA_W-1:0]   mag3;
    logic [DATA_W-1:0]   oldest3;
    logic                v3;
    logic                emit3;

    always_ff @(posedge clk) begin
        if (v2) begin
            win_mem[wr_ptr] <= mag_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3     <= 1'b0;
            emit3  <= 1'b0;
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            v3    <= v2;
            emit3 <= v2 && (fill >= FILL_LAST);
            if (v2) begin
                mag3    <= mag_r;
                oldest3 <= (fill == FILL_FULL) ? win_mem[wr_ptr] : '0;
                wr_ptr  <= wr_ptr + AVG_LOG2'(1);
                if (fill != FILL_FULL) begin
                    fill <= fill + (AVG_LOG2 + 1)'(1);
                end
            end
        end
    end

    // S3b: running sum and output; dout only moves when a pulse is issued
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_next;

    assign sum_next = sum + SUM_W'(mag3) - SUM_W'(oldest3);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= v3 && emit3;
            if (v3) begin
                sum <= sum_next;
                if (emit3) begin
                    dout <= sum_next[SUM_W-1:AVG_LOG2];
                end
            end
        end
    end

endmodule

// File: doc/am_envelope_det.md
# am_envelope_det

Parametrised AM envelope detector for the demodulation chain. It sits directly after the ADC sample stream. Each valid sample has a DC offset removed; the offset is either a fixed programmed value or an on-chip tracked estimate. The block then full-wave rectifies the result without wrap-around and smooths it with a power-of-two boxcar moving average, so no external FIR core is needed.

## Interface
Parameters:
- DATA_W, 16, sample width; input is unsigned offset-binary, output is unsigned magnitude.
- AVG_LOG2, 5, log2 of moving-average depth (DEPTH = 2^AVG_LOG2).
- DC_SHIFT, 10, DC-tracker time constant (2^DC_SHIFT samples).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_W  input sample.
- din_valid  in  1  din qualifier; may be high any cycle, no backpressure.
- dc_mode  in  1  0 = subtract dc_offset; 1 = subtract dc_est.
- dc_offset  in  DATA_W  fixed offset; also the tracker seed at reset.
- dout  out  DATA_W  envelope (averaged magnitude).
- dout_valid  out  1  one-cycle pulse per output sample.
- dc_est  out  DATA_W  current tracked DC estimate.

## Operation
- S1, on din_valid: off = dc_mode ? dc_est : dc_offset, sampled with the same sample. ac = din − off, computed at DATA_W+1 bits signed, so there is no wrap.
- S2: mag = |ac|. Its range is 0..2^DATA_W−1 and it fits DATA_W bits unsigned with no saturation.
- S3, moving average:
  - Circular buffer of DEPTH entries with a write pointer that wraps modulo DEPTH.
  - sum (DATA_W+AVG_LOG2 bits) <= sum + mag − oldest; the new mag overwrites oldest.
  - dout <= sum_next >> AVG_LOG2 (truncate).
- Warm-up:
  - fill counter counts accepted samples and saturates at DEPTH.
  - While fill < DEPTH, oldest is treated as 0, so the buffer array needs no reset.
  - dout_valid is suppressed until the DEPTH-th sample since reset reaches S3; from then on every sample yields one pulse.
- DC tracker, on every valid sample in both modes:
  - dc_acc (DATA_W+DC_SHIFT bits) <= dc_acc + din − (dc_acc >> DC_SHIFT).
  - dc_est = dc_acc >> DC_SHIFT, registered.
  - Fixed point: dc_est == din for constant din.
- Bubbles: the valid bit shifts through each stage every cycle. A stage's data registers update only when its incoming valid is high; otherwise they hold.
- dc_mode change mid-stream takes effect on the next valid sample. There is no flush, and the average mixes both regimes for DEPTH samples.

## Timing
- Latency: sample accepted at edge E0 → dout and dout_valid visible after edge E3 (3 cycles). Throughput is 1 sample per cycle.
- dout holds its last value when dout_valid is low.
- dc_est updates the cycle after each valid sample. The S1 of the following sample uses the updated value.
- Reset values:
  - dout = 0, dout_valid = 0.
  - All stage valids = 0, sum = 0, fill = 0, write pointer = 0.
  - dc_acc = dc_offset << DC_SHIFT; dc_est = dc_offset.
- Reset mid-operation: in-flight samples are discarded and dout_valid is low on the cycle after reset. Warm-up restarts, and the next DEPTH−1 samples produce no output.
- din_valid during rst is ignored.
- Simultaneous wrap of the write pointer and fill saturation: fill stops at DEPTH and the pointer returns to 0 on the same edge. There is no extra or lost output.

## Test plan
All scenarios use DATA_W=16, AVG_LOG2=5, DC_SHIFT=10.
1. rst, dc_mode=0, dc_offset=7602, din=8602 every cycle → no dout_valid for samples 1–31. Sample 32 gives dout_valid 3 cycles after acceptance with dout=1000, then continuous 1000.
2. Same setup, din alternating 8602/6602 → steady dout=1000 (rectification). Alternating 7702/7502 → dout=100.
3. Extremes, no wrap:
   - dc_offset=0, din=65535 → dout=65535.
   - dc_offset=65535, din=0 → dout=65535.
   - din=dc_offset=32768 → dout=0.
4. Gapped input: din_valid every 3rd cycle, sine-modulated data → dout values identical to the contiguous run. Output count = inputs − 31, each pulse exactly 3 cycles after its sample.
5. Auto DC:
   - rst with dc_offset=0, dc_mode=1, din constant 7602 → dc_est rises monotonically, reaches 7602 by sample 20000 and stays there.
   - Then dout decays to 0.
   - Reset with dc_offset=7602 gives dc_est=7602 immediately.
6. 1-cycle rst mid-stream (scenario 1 running) → next cycle: dout=0, dout_valid=0. Exactly 31 further samples with no output, then dout=1000.
